// File: rtl/pygmy_cfg.sv
// Shared configuration for the pygmy CPU/L2 NoC: port IDs and address-field geometry.
package pygmy_cfg;

  localparam int USB_CPU_PORT_ID    = 6;
  localparam int L2_PORT_CNT        = 4;
  localparam int BANK_ID_WIDTH      = $clog2(L2_PORT_CNT);
  localparam int CACHE_OFFSET_WIDTH = 6;
  localparam int PADDR_WIDTH        = 40;

endpackage

// File: rtl/usb_age_fifo.sv
// Circular buffer of bank IDs in USB read issue order; the caller only pushes when
// not full and only pops when not empty.
module usb_age_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = din;
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  // Storage is qualified by cnt, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/usb_ar_age_tracker.sv
// Orders outstanding USB reads across L2 banks so the NoC can release only the
// oldest bank's response; keeps per-bank counts and a sticky ordering-error flag.
module usb_ar_age_tracker
  import pygmy_cfg::PADDR_WIDTH, pygmy_cfg::CACHE_OFFSET_WIDTH;
#(
  parameter int L2_PORT_CNT = 4,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   usb_req_valid,
  input  logic                   usb_req_ready,
  input  logic                   usb_req_is_rd,
  input  logic [PADDR_WIDTH-1:0] usb_req_paddr,
  input  logic                   usb_resp_valid,
  input  logic                   usb_resp_ready,
  input  logic                   usb_resp_is_rd,
  output logic                   alloc_ready,
  output logic [L2_PORT_CNT-1:0] entry_vld_pbank,
  output logic [L2_PORT_CNT-1:0] is_oldest_pbank,
  output logic                   order_err
);

  localparam int BANK_ID_WIDTH = $clog2(L2_PORT_CNT);
  localparam int CW            = $clog2(DEPTH) + 1;

  logic [BANK_ID_WIDTH-1:0] req_bank;
  logic [BANK_ID_WIDTH-1:0] head;
  logic                     empty, full;
  logic                     push_fire, pop_fire, push_ok, pop_ok;
  logic [CW-1:0]            bank_cnt_q [L2_PORT_CNT];
  logic [CW-1:0]            bank_cnt_d [L2_PORT_CNT];
  logic                     order_err_q, order_err_d;
  logic                     unused_paddr;

  assign req_bank     = usb_req_paddr[CACHE_OFFSET_WIDTH +: BANK_ID_WIDTH];
  assign unused_paddr = ^{usb_req_paddr[PADDR_WIDTH-1:CACHE_OFFSET_WIDTH+BANK_ID_WIDTH],
                          usb_req_paddr[CACHE_OFFSET_WIDTH-1:0]};

  usb_age_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BANK_ID_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (req_bank),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  // A push while full or a pop while empty is dropped and flagged; the other
  // half of a same-cycle pair still proceeds.
  always_comb begin
    push_fire   = usb_req_valid & usb_req_ready & usb_req_is_rd;
    pop_fire    = usb_resp_valid & usb_resp_ready & usb_resp_is_rd;
    push_ok     = push_fire & ~full;
    pop_ok      = pop_fire & ~empty;
    order_err_d = order_err_q | (push_fire & full) | (pop_fire & empty);
    for (int b = 0; b < L2_PORT_CNT; b++) begin
      bank_cnt_d[b] = bank_cnt_q[b]
                    + CW'(push_ok && (req_bank == BANK_ID_WIDTH'(b)))
                    - CW'(pop_ok && (head == BANK_ID_WIDTH'(b)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < L2_PORT_CNT; b++) bank_cnt_q[b] <= '0;
      order_err_q <= 1'b0;
    end else begin
      for (int b = 0; b < L2_PORT_CNT; b++) bank_cnt_q[b] <= bank_cnt_d[b];
      order_err_q <= order_err_d;
    end
  end

  always_comb begin
    alloc_ready = ~full;
    order_err   = order_err_q;
    for (int b = 0; b < L2_PORT_CNT; b++) begin
      entry_vld_pbank[b] = (bank_cnt_q[b] != '0);
      is_oldest_pbank[b] = ~empty && (head == BANK_ID_WIDTH'(b));
    end
  end

endmodule

// File: tb/tb_usb_ar_age_tracker.sv
// Directed bench for usb_ar_age_tracker: a queue-based model checked every cycle,
// plus literal expectations at the interesting points.
module tb_usb_ar_age_tracker;

  localparam int NB    = 4;
  localparam int DEPTH = 8;
  localparam int PAW   = pygmy_cfg::PADDR_WIDTH;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           usb_req_valid = 1'b0;
  logic           usb_req_ready = 1'b0;
  logic           usb_req_is_rd = 1'b0;
  logic [PAW-1:0] usb_req_paddr = '0;
  logic           usb_resp_valid = 1'b0;
  logic           usb_resp_ready = 1'b0;
  logic           usb_resp_is_rd = 1'b0;
  logic           alloc_ready;
  logic [NB-1:0]  entry_vld_pbank;
  logic [NB-1:0]  is_oldest_pbank;
  logic           order_err;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  usb_ar_age_tracker #(.L2_PORT_CNT(NB), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .usb_req_valid   (usb_req_valid),
    .usb_req_ready   (usb_req_ready),
    .usb_req_is_rd   (usb_req_is_rd),
    .usb_req_paddr   (usb_req_paddr),
    .usb_resp_valid  (usb_resp_valid),
    .usb_resp_ready  (usb_resp_ready),
    .usb_resp_is_rd  (usb_resp_is_rd),
    .alloc_ready     (alloc_ready),
    .entry_vld_pbank (entry_vld_pbank),
    .is_oldest_pbank (is_oldest_pbank),
    .order_err       (order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding reads as a plain queue of bank numbers, oldest first.
  int unsigned mq[$];
  bit          m_err;

  always @(posedge clk) begin
    bit p, q, was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      p = usb_req_valid && usb_req_ready && usb_req_is_rd;
      q = usb_resp_valid && usb_resp_ready && usb_resp_is_rd;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (p && was_full)  m_err = 1'b1;
      if (q && was_empty) m_err = 1'b1;
      if (q && !was_empty) void'(mq.pop_front());
      if (p && !was_full)  mq.push_back((usb_req_paddr >> 6) % NB);
    end
  end

  always @(negedge clk) begin
    logic [NB-1:0] exp_vld, exp_old;
    if (chk_en) begin
      exp_vld = '0;
      foreach (mq[i]) exp_vld[mq[i]] = 1'b1;
      exp_old = (mq.size() != 0) ? (NB'(1) << mq[0]) : '0;
      chk("m_alloc_ready", 32'(alloc_ready), 32'(mq.size() != DEPTH));
      chk("m_entry_vld", 32'(entry_vld_pbank), 32'(exp_vld));
      chk("m_is_oldest", 32'(is_oldest_pbank), 32'(exp_old));
      chk("m_order_err", 32'(order_err), 32'(m_err));
    end
  end

  // One cycle of stimulus; returns at the following negedge.
  task automatic stepx(input bit pv, input bit prd, input int bank, input bit rdy,
                       input bit rv, input bit rrd, input bit rrdy);
    logic [PAW-1:0] a;
    a = {$urandom, $urandom};
    a[7:6] = bank[1:0];
    usb_req_valid  = pv;
    usb_req_is_rd  = prd;
    usb_req_ready  = rdy;
    usb_req_paddr  = a;
    usb_resp_valid = rv;
    usb_resp_is_rd = rrd;
    usb_resp_ready = rrdy;
    @(negedge clk);
  endtask

  task automatic push(input int bank);      stepx(1, 1, bank, 1, 0, 1, 1); endtask
  task automatic pop();                     stepx(0, 1, 0,    1, 1, 1, 1); endtask
  task automatic pushpop(input int bank);   stepx(1, 1, bank, 1, 1, 1, 1); endtask
  task automatic idle();                    stepx(0, 0, 0,    1, 0, 0, 1); endtask

  initial begin
    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_entry_vld", 32'(entry_vld_pbank), 32'h0);
    chk("rst_is_oldest", 32'(is_oldest_pbank), 32'h0);
    chk("rst_order_err", 32'(order_err), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle();

    // Ordered pair
    push(2);
    chk("pair_first_oldest", 32'(is_oldest_pbank), 32'h4);
    push(0);
    chk("pair_vld", 32'(entry_vld_pbank), 32'h5);
    chk("pair_oldest", 32'(is_oldest_pbank), 32'h4);
    pop();
    chk("pair_pop_vld", 32'(entry_vld_pbank), 32'h1);
    chk("pair_pop_oldest", 32'(is_oldest_pbank), 32'h1);
    pop();
    chk("pair_empty_vld", 32'(entry_vld_pbank), 32'h0);

    // Fill and drain three times so both pointers wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) push(3);
      chk("fill_alloc_ready", 32'(alloc_ready), 32'd0);
      chk("fill_vld", 32'(entry_vld_pbank), 32'h8);
      for (int i = 0; i < DEPTH - 1; i++) pop();
      chk("drain7_vld", 32'(entry_vld_pbank), 32'h8);
      pop();
      chk("drain_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("drain_vld", 32'(entry_vld_pbank), 32'h0);
      chk("drain_oldest", 32'(is_oldest_pbank), 32'h0);
    end

    // Same-cycle push and pop, same bank at head, three outstanding
    push(1);
    push(2);
    push(0);
    pushpop(1);
    chk("pp_oldest", 32'(is_oldest_pbank), 32'h4);
    chk("pp_vld", 32'(entry_vld_pbank), 32'h7);
    pop();
    chk("pp_pop1_oldest", 32'(is_oldest_pbank), 32'h1);
    pop();
    chk("pp_pop2_oldest", 32'(is_oldest_pbank), 32'h2);
    chk("pp_pop2_vld", 32'(entry_vld_pbank), 32'h2);
    pop();
    chk("pp_pop3_vld", 32'(entry_vld_pbank), 32'h0);
    // Same-cycle pair with different banks
    push(3);
    pushpop(0);
    chk("pp_diff_oldest", 32'(is_oldest_pbank), 32'h1);
    chk("pp_diff_vld", 32'(entry_vld_pbank), 32'h1);

    // Filtering: write request, write response and unaccepted response
    stepx(1, 0, 2, 1, 0, 1, 1);
    chk("filt_wr_req_vld", 32'(entry_vld_pbank), 32'h1);
    stepx(0, 1, 0, 1, 1, 0, 1);
    chk("filt_wr_resp_vld", 32'(entry_vld_pbank), 32'h1);
    stepx(0, 1, 0, 1, 1, 1, 0);
    chk("filt_no_ready_oldest", 32'(is_oldest_pbank), 32'h1);
    stepx(1, 1, 2, 0, 0, 1, 1);
    chk("filt_req_not_ready_vld", 32'(entry_vld_pbank), 32'h1);
    pop();

    // Mixed legal traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      stepx($urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
            alloc_ready, (mq.size() != 0) && ($urandom_range(0, 1) == 1), 1, 1);
    end
    for (int i = 0; i < DEPTH; i++) if (mq.size() != 0) pop();
    chk("mix_no_err", 32'(order_err), 32'd0);

    // Pop while empty
    pop();
    chk("err_pop_empty", 32'(order_err), 32'd1);
    chk("err_pop_empty_vld", 32'(entry_vld_pbank), 32'h0);
    idle();
    chk("err_sticky", 32'(order_err), 32'd1);

    // Reset mid-operation discards entries and clears the flag
    push(1);
    push(3);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst_mid_vld", 32'(entry_vld_pbank), 32'h0);
    chk("rst_mid_oldest", 32'(is_oldest_pbank), 32'h0);
    chk("rst_mid_err", 32'(order_err), 32'd0);

    // Pop while empty with a same-cycle push: the push still lands
    pushpop(2);
    chk("err_pp_err", 32'(order_err), 32'd1);
    chk("err_pp_vld", 32'(entry_vld_pbank), 32'h4);
    chk("err_pp_oldest", 32'(is_oldest_pbank), 32'h4);
    rst = 1'b1;
    idle();
    rst = 1'b0;

    // Forced push while full is dropped
    for (int i = 0; i < DEPTH; i++) push(3);
    push(0);
    chk("err_full_err", 32'(order_err), 32'd1);
    chk("err_full_alloc", 32'(alloc_ready), 32'd0);
    chk("err_full_vld", 32'(entry_vld_pbank), 32'h8);
    pushpop(0);
    chk("err_full_pp_vld", 32'(entry_vld_pbank), 32'h8);
    chk("err_full_pp_alloc", 32'(alloc_ready), 32'd1);
    for (int i = 0; i < DEPTH - 2; i++) pop();
    chk("err_full_drain_vld", 32'(entry_vld_pbank), 32'h8);
    pop();
    chk("err_full_last_vld", 32'(entry_vld_pbank), 32'h0);
    idle();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_ar_age_tracker.md
# usb_ar_age_tracker

Tracks outstanding USB (CPU port 6) read requests in issue order and produces the per-bank age information consumed by the CPU-to-L2 NoC response path. Each accepted USB read allocates an entry tagged with its L2 bank ID, and each USB read response delivered from the NoC retires the oldest entry. The NoC response path uses `entry_vld_pbank` / `is_oldest_pbank` to hold back any bank's USB response that is not the oldest, so USB sees read data in request order. The block sits beside the NoC, snooping the USB request port on its input side and the USB response port on its output side.

## Interface
- `L2_PORT_CNT`, 4: number of L2 banks; must be a power of two.
- `DEPTH`, 8: maximum outstanding USB reads; power of two, ≥2.
- `BANK_ID_WIDTH`, `$clog2(L2_PORT_CNT)`: derived, not overridden.

- `clk` in 1: clock; the only clock domain.
- `rst` in 1: synchronous, active-high reset.
- `usb_req_valid` in 1: USB request valid at the NoC input.
- `usb_req_ready` in 1: NoC ready for the USB request, already gated by `alloc_ready`.
- `usb_req_is_rd` in 1: request is a read (AR); only reads allocate.
- `usb_req_paddr` in PADDR_WIDTH: request physical address; bank = `paddr[CACHE_OFFSET_WIDTH +: BANK_ID_WIDTH]`.
- `usb_resp_valid` in 1: NoC response valid toward USB.
- `usb_resp_ready` in 1: USB accepts the response.
- `usb_resp_is_rd` in 1: response is for a read; only these retire entries.
- `alloc_ready` out 1: tracker can accept a new USB read.
- `entry_vld_pbank` out L2_PORT_CNT: bit b is 1 when any outstanding USB read targets bank b.
- `is_oldest_pbank` out L2_PORT_CNT: one-hot or zero; bit b is 1 when the oldest outstanding USB read targets bank b.
- `order_err` out 1: sticky error flag; cleared only by reset.

## Operation
- **push** = `usb_req_valid & usb_req_ready & usb_req_is_rd`. Writes the bank ID at `wptr`, advances `wptr`, and increments `bank_cnt[bank]`.
- **pop** = `usb_resp_valid & usb_resp_ready & usb_resp_is_rd`. Advances `rptr` and decrements `bank_cnt[head_bank]`.
- Each read produces exactly one response beat. Write responses are ignored.
- `cnt` is width `$clog2(DEPTH)+1`. `wptr` and `rptr` are width `$clog2(DEPTH)` and wrap naturally.
- `bank_cnt[b]` is width `$clog2(DEPTH)+1`.
- `alloc_ready = (cnt != DEPTH)`. Upstream must AND it into the USB request ready.
- `entry_vld_pbank[b] = (bank_cnt[b] != 0)`.
- `is_oldest_pbank[b] = (cnt != 0) & (fifo[rptr] == b)`.
- **Simultaneous push and pop:** `cnt` is unchanged and both pointers advance.
  - If the same bank is involved in both, `bank_cnt` is unchanged.
  - A same-cycle pop is not used to admit a push while full: `alloc_ready` stays 0.
- **Push while full:** the entry is dropped, `order_err` is set, and no state changes.
- **Pop while empty:** ignored, `order_err` is set, and no state changes.
  - Applies even if a push occurs in the same cycle; that push proceeds normally.
- **Reset mid-operation:** all outstanding entries are discarded.

## Timing
- All state updates on the rising edge of `clk`.
- Outputs are decoded only from registered state. There is no combinational path from any input to any output.
- **Push latency:** 1 cycle. After the edge on which push occurs, `entry_vld_pbank` shows the new entry. `is_oldest_pbank` updates too if the tracker was empty.
- **Pop latency:** 1 cycle. The next head's bank appears on `is_oldest_pbank` the cycle after the pop.
- **Reset values:**
  - `cnt`, `wptr`, `rptr`, all `bank_cnt` = 0.
  - `alloc_ready` = 1.
  - `entry_vld_pbank` = 0, `is_oldest_pbank` = 0, `order_err` = 0.
  - FIFO storage is not reset; it is qualified by `cnt`.

## Structure
- `USB_CPU_PORT_ID` (= 6), `CACHE_OFFSET_WIDTH`, `BANK_ID_WIDTH` and `PADDR_WIDTH` belong in `pygmy_cfg`. The NoC's hard-coded `6` is to be replaced by `USB_CPU_PORT_ID`.
- One sub-module: `usb_age_fifo`. It is a DEPTH×BANK_ID_WIDTH circular buffer with pointers and count, and exposes `head`, `empty` and `full`.
- The top level holds the per-bank counters, output decode and error flag.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `alloc_ready`=1, `entry_vld_pbank`=4'b0000, `is_oldest_pbank`=4'b0000, `order_err`=0.
- **Ordered pair:** push bank 2, then bank 0 → `entry_vld_pbank`=4'b0101, `is_oldest_pbank`=4'b0100. After one pop → `entry_vld_pbank`=4'b0001, `is_oldest_pbank`=4'b0001.
- **Fill and drain:** 8 pushes to bank 3 → `alloc_ready`=0 and `entry_vld_pbank`=4'b1000. Pop all 8 → `alloc_ready`=1 and `entry_vld_pbank`=0 on the cycle after the last pop. Repeat twice to check pointer wrap.
- **Same-cycle push and pop:** with head = bank 1 and `cnt`=3, push bank 1 and pop together → `cnt` stays 3, `bank_cnt[1]` unchanged, new head shown next cycle.
- **Filtering:** a write request fire, or a write response fire, changes no output.
- **Errors:** pop while empty → `order_err`=1 next cycle, `entry_vld_pbank` still 0. Force push while full → `order_err`=1, `cnt` stays 8.
